// File: rtl/demux_1_8_pkg.sv
// rtl/demux_1_8_pkg.sv - shared sizes and reset value for the 1-to-8 registered demux
package demux_1_8_pkg;

    localparam int SEL_W = 3;
    localparam int N_OUT = 2 ** SEL_W;

    localparam logic [N_OUT-1:0] Y_RST = 8'h00;

endpackage

// File: rtl/demux_1_8_dec.sv
// rtl/demux_1_8_dec.sv - combinational 3-to-8 decoder gated by the data bit
module demux_1_8_dec
    import demux_1_8_pkg::*;
#(
    parameter int SEL_W = demux_1_8_pkg::SEL_W,
    parameter int N_OUT = demux_1_8_pkg::N_OUT
) (
    input  logic             a,
    input  logic [SEL_W-1:0] s,
    output logic [N_OUT-1:0] y_next
);

    // Only the selected bit can carry a, so the result is one-hot or zero by construction.
    always_comb begin
        y_next    = '0;
        y_next[s] = a;
    end

endmodule

// File: rtl/demux_1_8.sv
// rtl/demux_1_8.sv - registered 1-to-8 demux; optional y_valid under DEMUX_1_8_VALID_EN
module demux_1_8
    import demux_1_8_pkg::*;
#(
    parameter int SEL_W = demux_1_8_pkg::SEL_W,
    parameter int N_OUT = demux_1_8_pkg::N_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic [SEL_W-1:0] s,
    output logic [N_OUT-1:0] y
`ifdef DEMUX_1_8_VALID_EN
    ,
    output logic             y_valid
`endif
);

    logic [N_OUT-1:0] dec_y;
    logic [N_OUT-1:0] y_d;
    logic [N_OUT-1:0] y_q;

    demux_1_8_dec #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_dec (
        .a      (a),
        .s      (s),
        .y_next (dec_y)
    );

    always_comb begin
        y_d = y_q;
        if (en) begin
            y_d = dec_y;
        end
    end

    // Reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= Y_RST;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

`ifdef DEMUX_1_8_VALID_EN
    logic y_valid_d;
    logic y_valid_q;

    always_comb begin
        y_valid_d = en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= y_valid_d;
        end
    end

    assign y_valid = y_valid_q;
`endif

endmodule

// File: tb/tb_demux_1_8.sv
// tb/tb_demux_1_8.sv - randomized self-checking bench for demux_1_8 (DEMUX_1_8_VALID_EN optional)
module tb_demux_1_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       a;
    logic [2:0] s;
    logic [7:0] y;
`ifdef DEMUX_1_8_VALID_EN
    logic       y_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_y;
    logic       exp_v;
    bit         model_known = 1'b0;

    always #5 clk = ~clk;

    demux_1_8 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .s       (s),
        .y       (y)
`ifdef DEMUX_1_8_VALID_EN
        ,
        .y_valid (y_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the selected output carries a, i.e. y = a ? 2**s : 0; en=0 holds; rst clears.
    task automatic step(input logic r, input logic e, input logic av, input logic [2:0] sv);
        @(negedge clk);
        rst = r;
        en  = e;
        a   = av;
        s   = sv;
        #1;
        if (model_known) check("no_comb_path", y, exp_y);
        @(posedge clk);
        if (r) begin
            exp_y = 8'h00;
            exp_v = 1'b0;
        end else begin
            exp_v = e;
            if (e) exp_y = av ? 8'(2 ** sv) : 8'h00;
        end
        model_known = 1'b1;
        #1;
        check("y_model", y, exp_y);
        check("at_most_one_hot", 32'($countones(y) <= 1), 32'd1);
`ifdef DEMUX_1_8_VALID_EN
        check("y_valid_model", y_valid, exp_v);
`endif
    endtask

    logic [2:0] sel_tbl [5];
    logic [7:0] y_tbl   [5];

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = 1'b0;
        s   = 3'd0;

        // Reset for two cycles, then idle
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        check("reset_y", y, 8'h00);
        step(1'b0, 1'b0, 1'b1, 3'd5);
        step(1'b0, 1'b0, 1'b1, 3'd2);
        check("idle_after_reset_y", y, 8'h00);
`ifdef DEMUX_1_8_VALID_EN
        check("idle_after_reset_valid", y_valid, 1'b0);
`endif

        // Back-to-back routing of a=1
        sel_tbl = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd5};
        y_tbl   = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b10000000, 8'b00100000};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, sel_tbl[i]);
            check($sformatf("route_s%0d", sel_tbl[i]), y, y_tbl[i]);
        end

        // a=0 clears regardless of select
        step(1'b0, 1'b1, 1'b0, 3'd3);
        check("a0_s3", y, 8'h00);
        step(1'b0, 1'b1, 1'b0, 3'd6);
        check("a0_s6", y, 8'h00);

        // Hold with en=0
        step(1'b0, 1'b1, 1'b1, 3'd5);
        check("load_s5", y, 8'b00100000);
        step(1'b0, 1'b0, 1'b1, 3'd2);
        check("hold_en0", y, 8'b00100000);

        // Reset priority, then first update after reset
        step(1'b1, 1'b1, 1'b1, 3'd7);
        check("rst_over_en", y, 8'h00);
        step(1'b0, 1'b1, 1'b1, 3'd7);
        check("first_after_rst", y, 8'b10000000);

`ifdef DEMUX_1_8_VALID_EN
        step(1'b0, 1'b1, 1'b1, 3'd1);
        check("valid_pulse_1", y_valid, 1'b1);
        step(1'b0, 1'b0, 1'b1, 3'd1);
        check("valid_pulse_0", y_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0, 3'd4);
        check("valid_pulse_1b", y_valid, 1'b1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom),
                 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
